rand_scheduler: RTL and testbench
=================================

Name: rand_scheduler

Overview:
- Shares one 8-bit XNOR-feedback LFSR random source among NREQ game requesters, e.g. gold placement, rock placement and hook jitter.
- Requests are arbitrated round-robin.
- The block snapshots the LFSR for the winner and reduces the value to the range 0..limit-1 by sequential repeated subtraction.
- It returns the result with a one-cycle grant/valid pulse.

Parameters:
- NREQ, 4, number of requesters (2..8).
- SEED, 8'h00, LFSR reset value. 8'hFF is illegal and is mapped to 8'h00.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous reset, active-low
- req  input  NREQ  per-requester request level; held until the matching gnt bit
- limit  input  8*NREQ  per-requester range; requester i uses limit[8*i+7:8*i]; 0 means full range, no reduction
- seed_we  input  1  load seed_in into the LFSR this cycle
- seed_in  input  8  new LFSR state
- gnt  output  NREQ  one-hot grant, high only in the DONE cycle
- rnd_out  output  8  reduced random value, valid while rnd_valid
- rnd_valid  output  1  one-cycle result strobe
- busy  output  1  high in CAPTURE-completed states (REDUCE, DONE)
- lfsr_q  output  8  current LFSR state, for debug and verification

Behaviour:
- Reset (rst low, asynchronous):
  - lfsr = SEED, or 00 if SEED == FF.
  - state = IDLE, ptr = 0, acc = 0, lim = 0, idx = 0.
  - gnt = 0, rnd_out = 0, rnd_valid = 0, busy = 0.
- LFSR:
  - Free-running; advances every clock in every state: next = {s[6:0], ~(s[7]^s[6])}.
  - Sequence from 00: 00, 01, 03, 07, 0F, 1F, 3F, 7F, FE, FD, FB, ...
  - seed_we has priority over advance. It loads seed_in; FF is loaded as 00 because FF is the XNOR lock-up state.
  - seed_we never alters acc or an operation in flight.
  - Lock-up guard: if the state ever reads FF, the next state is 00.
- Arbitration, IDLE state:
  - Search req starting at index ptr, ascending, wrapping at NREQ.
  - The first set bit wins and becomes idx.
  - On that edge: acc = lfsr_q (pre-advance value), lim = limit of idx, state goes to REDUCE.
  - If no req is set, stay in IDLE.
- REDUCE state, one decision per edge:
  - If lim == 0 or acc < lim, go to DONE.
  - Otherwise acc = acc - lim (8-bit, never underflows); stay in REDUCE.
- DONE state, exactly one cycle:
  - gnt[idx] = 1, rnd_valid = 1, rnd_out = acc.
  - On the next edge: ptr = (idx+1) mod NREQ, state goes to IDLE.
  - rnd_out holds its value after DONE until the next DONE.
- Latency:
  - Let v = captured value and q = floor(v/lim), with q = 0 if lim == 0.
  - Count the capture edge as edge 1. rnd_valid is high in the cycle after edge q+2.
  - Worst case (v = 254, lim = 1) is 256 cycles.
- Boundary conditions:
  - A req drop after capture does not cancel the operation; gnt still pulses for idx.
  - A limit change after capture is ignored.
  - Requests are not accepted in REDUCE or DONE. The earliest next capture is the edge after DONE, since the IDLE decision happens in the following cycle.
  - The bubble is one IDLE cycle minimum between grants.
  - Result range: rnd_out < lim when lim != 0; 0..254 when lim == 0 (FF is never produced).
  - Reset mid-operation aborts immediately to the reset values; there is no pending gnt afterwards.

Test Plan:
- Reset with SEED = 00 and no req → lfsr_q steps 00, 01, 03, 07, 0F, 1F, 3F, 7F, FE, FD; gnt = 0, rnd_valid = 0, busy = 0 throughout.
- Assert req[0] with limit 10 when lfsr_q = 7F → acc 127, q = 12; rnd_valid and gnt = 0001 high in the cycle after edge 14; rnd_out = 7 (0x07).
- seed_we with seed_in = FF → lfsr_q = 00 next cycle, then 01. seed_we with 7F in IDLE, then req[1] with limit 0 on the next edge → rnd_out = FE after edge 2, gnt = 0010.
- All req = 1111, each limit = 0, held continuously → grants cycle 0001, 0010, 0100, 1000, 0001, ...; each rnd_valid pulse lasts exactly 1 cycle.
- req[2] pulsed for one cycle with limit 3 captured at lfsr_q = 3F (63) → completes with rnd_out = 0, gnt = 0100 despite req dropping; ptr then favours req[3] over req[0] when both request.
- rst low during REDUCE (lim = 1, v = FE) → outputs 0 and lfsr = SEED immediately; no gnt pulse after rst returns high until req is re-sampled.

Source files
------------

// File: rtl/rand_scheduler.sv
// Round-robin scheduler sharing one 8-bit XNOR LFSR among NREQ requesters;
// the winner's snapshot is reduced modulo its limit by repeated subtraction.
module rand_scheduler #(
    parameter int          NREQ = 4,
    parameter logic [7:0]  SEED = 8'h00
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [8*NREQ-1:0]   limit,
    input  logic                seed_we,
    input  logic [7:0]          seed_in,
    output logic [NREQ-1:0]     gnt,
    output logic [7:0]          rnd_out,
    output logic                rnd_valid,
    output logic                busy,
    output logic [7:0]          lfsr_q
);

    localparam int         IW      = (NREQ > 2) ? $clog2(NREQ) : 1;
    // All-ones is the XNOR lock-up state, so it is never allowed as a start value.
    localparam logic [7:0] SEED_OK = (SEED == 8'hFF) ? 8'h00 : SEED;

    typedef enum logic [1:0] {IDLE, REDUCE, DONE} state_t;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   idx;
    logic [7:0]      acc;
    logic [7:0]      lim;

    logic            found;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   cand;
    logic [7:0]      win_lim;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= SEED_OK;
        end else if (seed_we) begin
            lfsr_q <= (seed_in == 8'hFF) ? 8'h00 : seed_in;
        end else if (lfsr_q == 8'hFF) begin
            lfsr_q <= 8'h00;
        end else begin
            lfsr_q <= {lfsr_q[6:0], ~(lfsr_q[7] ^ lfsr_q[6])};
        end
    end

    // NOTE: every combinational output gets a default before the loop, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        win_lim = 8'h00;
        cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IW'((int'(ptr) + k) % NREQ);
            if (!found && req[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            if (win_idx == IW'(k)) begin
                win_lim = limit[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ptr       <= '0;
            idx       <= '0;
            acc       <= 8'h00;
            lim       <= 8'h00;
            gnt       <= '0;
            rnd_out   <= 8'h00;
            rnd_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        acc   <= lfsr_q;
                        lim   <= win_lim;
                        idx   <= win_idx;
                        busy  <= 1'b1;
                        state <= REDUCE;
                    end
                end
                REDUCE: begin
                    // lim == 0 means full range: the snapshot passes through.
                    if (lim == 8'h00 || acc < lim) begin
                        gnt       <= NREQ'(1) << idx;
                        rnd_out   <= acc;
                        rnd_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        acc <= acc - lim;
                    end
                end
                DONE: begin
                    gnt       <= '0;
                    rnd_valid <= 1'b0;
                    busy      <= 1'b0;
                    ptr       <= (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rand_scheduler.sv
// Directed bench for rand_scheduler: LFSR sequence, reduction results,
// round-robin order, dropped requests and mid-operation reset.
module tb_rand_scheduler;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] limit;
    logic        seed_we;
    logic [7:0]  seed_in;
    logic [3:0]  gnt;
    logic [7:0]  rnd_out;
    logic        rnd_valid;
    logic        busy;
    logic [7:0]  lfsr_q;

    int checks = 0;
    int errors = 0;

    rand_scheduler #(.NREQ(4), .SEED(8'h00)) dut (
        .clk(clk), .rst(rst), .req(req), .limit(limit),
        .seed_we(seed_we), .seed_in(seed_in), .gnt(gnt),
        .rnd_out(rnd_out), .rnd_valid(rnd_valid), .busy(busy), .lfsr_q(lfsr_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [7:0] exp_lfsr;
        logic [3:0] exp_gnt;
        logic       exp_valid;
        logic       exp_busy;
    } free_vec_t;

    typedef struct {
        logic [3:0] exp_gnt;
        logic [7:0] exp_out;
    } rr_vec_t;

    free_vec_t free_tbl [10];
    rr_vec_t   rr_tbl   [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance until rnd_valid is seen, counting edges; bounded.
    task automatic wait_valid(output int edges);
        edges = 0;
        do begin
            step();
            edges++;
        end while (!rnd_valid && edges < 400);
        check("valid_seen", 32'(rnd_valid), 32'(1'b1));
    endtask

    int e;
    int pulses;

    initial begin
        free_tbl[0] = '{4'b0000, 8'h00, 4'b0000, 1'b0, 1'b0};
        free_tbl[1] = '{4'b0000, 8'h01, 4'b0000, 1'b0, 1'b0};
        free_tbl[2] = '{4'b0000, 8'h03, 4'b0000, 1'b0, 1'b0};
        free_tbl[3] = '{4'b0000, 8'h07, 4'b0000, 1'b0, 1'b0};
        free_tbl[4] = '{4'b0000, 8'h0F, 4'b0000, 1'b0, 1'b0};
        free_tbl[5] = '{4'b0000, 8'h1F, 4'b0000, 1'b0, 1'b0};
        free_tbl[6] = '{4'b0000, 8'h3F, 4'b0000, 1'b0, 1'b0};
        free_tbl[7] = '{4'b0000, 8'h7F, 4'b0000, 1'b0, 1'b0};
        free_tbl[8] = '{4'b0000, 8'hFE, 4'b0000, 1'b0, 1'b0};
        free_tbl[9] = '{4'b0000, 8'hFD, 4'b0000, 1'b0, 1'b0};

        // Captures land on LFSR positions 0,3,6,...,21 after reset.
        rr_tbl[0] = '{4'b0001, 8'h00};
        rr_tbl[1] = '{4'b0010, 8'h07};
        rr_tbl[2] = '{4'b0100, 8'h3F};
        rr_tbl[3] = '{4'b1000, 8'hFD};
        rr_tbl[4] = '{4'b0001, 8'hEF};
        rr_tbl[5] = '{4'b0010, 8'h7E};
        rr_tbl[6] = '{4'b0100, 8'hF3};
        rr_tbl[7] = '{4'b1000, 8'h9F};

        rst = 1'b0; req = '0; limit = '0; seed_we = 1'b0; seed_in = 8'h00;
        #12;
        check("rst_lfsr",  32'(lfsr_q),    32'(8'h00));
        check("rst_out",   32'(rnd_out),   32'(8'h00));
        check("rst_valid", 32'(rnd_valid), 32'(1'b0));
        check("rst_gnt",   32'(gnt),       32'(4'b0000));
        check("rst_busy",  32'(busy),      32'(1'b0));
        rst = 1'b1;

        // Free-running LFSR with no requests.
        for (int i = 0; i < 10; i++) begin
            req = free_tbl[i].req;
            check($sformatf("free_lfsr[%0d]", i),  32'(lfsr_q),    32'(free_tbl[i].exp_lfsr));
            check($sformatf("free_gnt[%0d]", i),   32'(gnt),       32'(free_tbl[i].exp_gnt));
            check($sformatf("free_valid[%0d]", i), 32'(rnd_valid), 32'(free_tbl[i].exp_valid));
            check($sformatf("free_busy[%0d]", i),  32'(busy),      32'(free_tbl[i].exp_busy));
            step();
        end

        // 127 mod 10 = 7, q = 12, valid after edge 14.
        seed_we = 1'b1; seed_in = 8'h7F;
        step();
        seed_we = 1'b0;
        check("ld7f_lfsr", 32'(lfsr_q), 32'(8'h7F));
        req = 4'b0001; limit[7:0] = 8'd10;
        step();
        check("r10_busy", 32'(busy), 32'(1'b1));
        wait_valid(e);
        check("r10_lat",  32'(e + 1),  32'(14));
        check("r10_out",  32'(rnd_out), 32'(8'h07));
        check("r10_gnt",  32'(gnt),     32'(4'b0001));
        req = 4'b0000;
        step();
        check("r10_vld_off", 32'(rnd_valid), 32'(1'b0));
        check("r10_gnt_off", 32'(gnt),       32'(4'b0000));
        check("r10_busy_off", 32'(busy),     32'(1'b0));
        check("r10_hold",    32'(rnd_out),   32'(8'h07));

        // Seed FF maps to 00; seed 7F then req[1] full range captures FE.
        seed_we = 1'b1; seed_in = 8'hFF;
        step();
        seed_we = 1'b0;
        check("ldff_lfsr0", 32'(lfsr_q), 32'(8'h00));
        step();
        check("ldff_lfsr1", 32'(lfsr_q), 32'(8'h01));
        seed_we = 1'b1; seed_in = 8'h7F;
        step();
        seed_we = 1'b0;
        step();
        req = 4'b0010; limit[15:8] = 8'd0;
        wait_valid(e);
        check("fe_lat", 32'(e),       32'(2));
        check("fe_out", 32'(rnd_out), 32'(8'hFE));
        check("fe_gnt", 32'(gnt),     32'(4'b0010));
        req = 4'b0000;
        step();

        // Reset, then all requesters held with full range.
        rst = 1'b0;
        #3;
        check("rst2_lfsr", 32'(lfsr_q), 32'(8'h00));
        @(negedge clk);
        rst = 1'b1; req = 4'b1111; limit = '0;
        for (int i = 0; i < 8; i++) begin
            wait_valid(e);
            check($sformatf("rr_lat[%0d]", i), 32'(e),       32'(2));
            check($sformatf("rr_gnt[%0d]", i), 32'(gnt),     32'(rr_tbl[i].exp_gnt));
            check($sformatf("rr_out[%0d]", i), 32'(rnd_out), 32'(rr_tbl[i].exp_out));
            if (i == 7) req = 4'b0000;
            step();
            check($sformatf("rr_pulse[%0d]", i), 32'(rnd_valid), 32'(1'b0));
        end

        // req[2] pulsed one cycle at 3F, limit changed after capture.
        seed_we = 1'b1; seed_in = 8'h3F; limit[23:16] = 8'd3;
        step();
        seed_we = 1'b0; req = 4'b0100;
        step();
        req = 4'b0000; limit[23:16] = 8'd7;
        wait_valid(e);
        check("drop_lat", 32'(e + 1),  32'(23));
        check("drop_out", 32'(rnd_out), 32'(8'h00));
        check("drop_gnt", 32'(gnt),     32'(4'b0100));
        step();
        req = 4'b1001; limit = '0;
        wait_valid(e);
        check("ptr_gnt3", 32'(gnt), 32'(4'b1000));
        req = 4'b0001;
        step();
        wait_valid(e);
        check("ptr_gnt0", 32'(gnt), 32'(4'b0001));
        req = 4'b0000;
        step();

        // Reset in the middle of a long reduction (FE with lim 1).
        seed_we = 1'b1; seed_in = 8'hFE; limit[7:0] = 8'd1;
        step();
        seed_we = 1'b0; req = 4'b0001;
        step();
        req = 4'b0000;
        repeat (5) step();
        check("mid_busy", 32'(busy), 32'(1'b1));
        #2;
        rst = 1'b0;
        #1;
        check("mid_lfsr",  32'(lfsr_q),    32'(8'h00));
        check("mid_busy0", 32'(busy),      32'(1'b0));
        check("mid_valid", 32'(rnd_valid), 32'(1'b0));
        check("mid_gnt",   32'(gnt),       32'(4'b0000));
        check("mid_out",   32'(rnd_out),   32'(8'h00));
        @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (rnd_valid || gnt != 4'b0000 || busy) pulses++;
        end
        check("post_rst_idle", 32'(pulses), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
